sim_io_monitor: RTL

//  Simulation-side console/halt endpoint sitting beside riscv_top under the testbench.

---
 rtl/sim_io_monitor.sv | 119 +++++++++++
 1 files changed

// File: rtl/sim_io_monitor.sv
// Simulation console/halt endpoint: buffers CPU character writes, drains them to a sink,
// and flags run completion on halt or timeout. Define SIM_IO_DISPLAY_EN for console printing.
module sim_io_monitor #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 150000000
) (
    input  logic        extern_clk,
    input  logic        extern_rst,
    input  logic        io_wr,
    input  logic [1:0]  io_addr,
    input  logic [7:0]  io_wdata,
    output logic        io_full,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        sim_done,
    output logic [7:0]  exit_code,
    output logic        timeout,
    output logic        overflow,
    output logic [31:0] cycle_cnt
);

    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          active, pop, push_req, push_ok, halt_req, timeout_hit;

    assign active    = (state != DONE);
    assign con_valid = (count != '0) && active;
    assign con_data  = mem[rd_ptr];
    assign io_full   = (count == (PW+1)'(DEPTH));
    assign sim_done  = (state == DONE);
    assign pop       = con_valid && con_ready;
    assign push_req  = (state == RUN) && io_wr && (io_addr == 2'd0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok   = push_req && (!io_full || pop);
    assign halt_req  = (state == RUN) && io_wr && (io_addr == 2'd1);
    assign timeout_hit = active && (TIMEOUT_CYCLES != 0) &&
                         (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge extern_clk) begin
        if (extern_rst) state <= RUN;
        else            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (halt_req) state_next = DRAIN;
            DRAIN:   if (count == '0) state_next = DONE;
            default: state_next = DONE;
        endcase
        if (timeout_hit) state_next = DONE;
    end

    always_ff @(posedge extern_clk) begin
        if (push_ok) mem[wr_ptr] <= io_wdata;
    end

    always_ff @(posedge extern_clk) begin
        if (extern_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Timeout takes priority over a halt write landing in the same cycle.
    always_ff @(posedge extern_clk) begin
        if (extern_rst) begin
            exit_code <= '0;
            timeout   <= 1'b0;
            overflow  <= 1'b0;
            cycle_cnt <= '0;
        end else begin
            if (timeout_hit) begin
                timeout   <= 1'b1;
                exit_code <= 8'hFF;
            end else if (halt_req) begin
                exit_code <= io_wdata;
            end
            if (push_req && !push_ok) overflow <= 1'b1;
            if (active && (cycle_cnt != '1)) cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

`ifdef SIM_IO_DISPLAY_EN
    logic reported;

    always_ff @(posedge extern_clk) begin
        if (extern_rst) begin
            reported <= 1'b0;
        end else begin
            if (pop) $write("%c", con_data);
            if (sim_done && !reported) begin
                $display("[sim_io_monitor] exit_code=%0d timeout=%0d cycles=%0d",
                         exit_code, timeout, cycle_cnt);
                reported <= 1'b1;
            end
        end
    end
`else
    // Synthesizable build: no console side effects.
`endif

endmodule
